sensor_responder: RTL

Node-side end of the arbiter request/response link. It receives a one-byte request over UART RX, matches the address nibble against its own node address and decodes the command nibble. It then transmits a three-byte response over UART TX: header, data and checksum. It sits in each sensor node, between the serial line from the arbiter and the local sensor register.

---
 rtl/sensor_responder_pkg.sv | 23 ++
 rtl/uart_rx.sv | 79 +++++++
 rtl/uart_tx.sv | 90 +++++++++
 rtl/sensor_responder.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sensor_responder_pkg.sv
// Shared definitions for the arbiter request/response link.
// Holds the command codes, the responder FSM state encoding and the
// checksum helper so that both ends of the link compute identical bytes.
package sensor_responder_pkg;

    localparam logic [3:0] CMD_READ   = 4'h1;
    localparam logic [3:0] CMD_STATUS = 4'h2;
    localparam logic [3:0] CMD_PING   = 4'hF;
    localparam logic [3:0] CODE_NACK  = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } resp_state_e;

    // 8-bit sum, carry discarded.
    function automatic logic [7:0] resp_checksum(input logic [7:0] hdr, input logic [7:0] data);
        return hdr + data;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receiver core, 8N1, LSB first.
// Ports:
//   i_Clock     - system clock
//   i_Rx_Serial - serial input (idles high)
//   o_Rx_DV     - one-cycle strobe when o_Rx_Byte holds a new byte
//   o_Rx_Byte   - last received byte
// The core has no reset; its state register powers up in the idle encoding.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_Clock,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_TC = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e       state_q;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      byte_q;
    logic            dv_q;
    logic            rx_s;

    assign rx_s      = sync_q[1];
    assign o_Rx_DV   = dv_q;
    assign o_Rx_Byte = byte_q;

    always_ff @(posedge i_Clock) begin
        sync_q <= {sync_q[0], i_Rx_Serial};
        dv_q   <= 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    cnt_q   <= HALF_TC;
                    state_q <= RX_START;
                end
            end
            RX_START: begin
                // Re-check at mid start bit so a glitch is not taken as a frame.
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else if (!rx_s) begin
                    cnt_q   <= BIT_TC;
                    bit_q   <= 3'd0;
                    state_q <= RX_DATA;
                end else begin
                    state_q <= RX_IDLE;
                end
            end
            RX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    byte_q <= {rx_s, byte_q[7:1]};
                    cnt_q  <= BIT_TC;
                    if (bit_q == 3'd7) state_q <= RX_STOP;
                    else               bit_q   <= bit_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    dv_q    <= 1'b1;
                    state_q <= RX_IDLE;
                end
            end
            default: state_q <= RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter core, 8N1, LSB first.
// Ports:
//   i_Clock     - system clock
//   i_Tx_DV     - start strobe, accepted only while idle
//   i_Tx_Byte   - byte to send, captured with i_Tx_DV
//   o_Tx_Active - high while a frame is on the line
//   o_Tx_Serial - serial output (idles high)
//   o_Tx_Done   - one-cycle strobe at the end of the stop bit
// The core has no reset: a frame in progress always runs to completion.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       i_Clock,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_TC = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

    tx_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    logic          ser_q;
    logic          act_q;
    logic          done_q;

    assign o_Tx_Active = act_q;
    assign o_Tx_Serial = ser_q;
    assign o_Tx_Done   = done_q;

    always_ff @(posedge i_Clock) begin
        done_q <= 1'b0;
        case (state_q)
            TX_IDLE: begin
                ser_q <= 1'b1;
                if (i_Tx_DV) begin
                    sh_q    <= i_Tx_Byte;
                    ser_q   <= 1'b0;
                    act_q   <= 1'b1;
                    cnt_q   <= BIT_TC;
                    state_q <= TX_START;
                end
            end
            TX_START: begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    ser_q   <= sh_q[0];
                    sh_q    <= {1'b0, sh_q[7:1]};
                    bit_q   <= 3'd0;
                    cnt_q   <= BIT_TC;
                    state_q <= TX_DATA;
                end
            end
            TX_DATA: begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    cnt_q <= BIT_TC;
                    if (bit_q == 3'd7) begin
                        ser_q   <= 1'b1;
                        state_q <= TX_STOP;
                    end else begin
                        ser_q <= sh_q[0];
                        sh_q  <= {1'b0, sh_q[7:1]};
                        bit_q <= bit_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    act_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= TX_IDLE;
                end
            end
            default: state_q <= TX_IDLE;
        endcase
    end

endmodule

// File: rtl/sensor_responder.sv
// Node-side responder for the arbiter link.
// Receives a one-byte request {addr, cmd}; if addr matches NODE_ADDR it
// answers with three bytes: header {NODE_ADDR, code}, data, checksum.
// Ports:
//   clk         - system clock
//   reset       - synchronous active-low reset
//   rx          - serial line from the arbiter
//   sensor_data - local sensor value, captured while decoding a request
//   tx          - serial line to the arbiter
//   busy        - high while a request is being answered
//   resp_done   - one-cycle pulse at the end of the checksum byte
//   drop_count  - saturating count of matching requests arriving while busy
//
// state        | meaning
// ST_IDLE      | waiting for a request addressed to this node
// ST_DECODE    | build header/data/checksum into the response buffer
// ST_SEND      | wait for the transmitter to be idle, then strobe one byte
// ST_WAIT_DONE | wait for the byte to finish; advance or finish the response
module sensor_responder
    import sensor_responder_pkg::*;
#(
    parameter logic [3:0] NODE_ADDR    = 4'h1,
    parameter int         CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic [7:0] sensor_data,
    output logic       tx,
    output logic       busy,
    output logic       resp_done,
    output logic [7:0] drop_count
);

    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_done;
    logic       addr_hit;

    resp_state_e state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [7:0]  hdr_q, hdr_d;
    logic [7:0]  dat_q, dat_d;
    logic [7:0]  sum_q, sum_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  drop_q, drop_d;
    logic [3:0]  code;
    logic [7:0]  data;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_rx (
        .i_Clock     (clk),
        .i_Rx_Serial (rx),
        .o_Rx_DV     (rx_dv),
        .o_Rx_Byte   (rx_byte)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
        .i_Clock     (clk),
        .i_Tx_DV     (tx_dv),
        .i_Tx_Byte   (tx_byte),
        .o_Tx_Active (tx_active),
        .o_Tx_Serial (tx),
        .o_Tx_Done   (tx_done)
    );

    assign addr_hit   = rx_dv && (rx_byte[7:4] == NODE_ADDR);
    assign busy       = (state_q != ST_IDLE);
    assign drop_count = drop_q;
    assign tx_byte    = (idx_q == 2'd0) ? hdr_q :
                        (idx_q == 2'd1) ? dat_q : sum_q;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        hdr_d     = hdr_q;
        dat_d     = dat_q;
        sum_d     = sum_q;
        idx_d     = idx_q;
        drop_d    = drop_q;
        tx_dv     = 1'b0;
        resp_done = 1'b0;
        code      = CODE_NACK;
        data      = 8'h00;

        // Any matching request outside IDLE is lost, including one that
        // coincides with the final o_Tx_Done.
        if (addr_hit && (state_q != ST_IDLE) && (drop_q != 8'hFF))
            drop_d = drop_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (addr_hit) begin
                    cmd_d   = rx_byte[3:0];
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (cmd_q)
                    CMD_READ:   begin code = CMD_READ;   data = sensor_data;        end
                    CMD_STATUS: begin code = CMD_STATUS; data = drop_q;             end
                    CMD_PING:   begin code = CMD_PING;   data = {4'h0, NODE_ADDR};  end
                    default:    begin code = CODE_NACK;  data = 8'h00;              end
                endcase
                hdr_d   = {NODE_ADDR, code};
                dat_d   = data;
                sum_d   = resp_checksum({NODE_ADDR, code}, data);
                idx_d   = 2'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                // After a mid-response reset the old frame may still be on the wire.
                if (!tx_active) begin
                    tx_dv   = 1'b1;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    if (idx_q == 2'd2) begin
                        resp_done = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= 4'h0;
            hdr_q   <= 8'h00;
            dat_q   <= 8'h00;
            sum_q   <= 8'h00;
            idx_q   <= 2'd0;
            drop_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            hdr_q   <= hdr_d;
            dat_q   <= dat_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

endmodule
